// File: rtl/shared_alu_pkg.sv
// Shared types for the handshaked shared ALU: op codes, FSM states, result flags.
// The MUL state only exists when SHARED_ALU_MUL_EN is defined.
package shared_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

`ifdef SHARED_ALU_MUL_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_MUL  = 2'd2
  } state_e;
`else
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;
`endif

  typedef struct packed {
    logic carry;
    logic zero;
    logic ovf;
    logic err;
  } flags_t;

endpackage

// File: rtl/shared_alu_mul_iter.sv
// Iterative shift-add multiplier: load performs the first step, each further step
// retires one multiplier bit; o_done rises once all WIDTH bits are consumed.
module shared_alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [2*WIDTH-1:0] r_prod;

  logic [2*WIDTH-1:0] w_src;
  logic [2*WIDTH-1:0] w_next;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH:0]     w_sum;

  // Upper half accumulates the multiplicand, lower half holds the unconsumed multiplier bits.
  always_comb begin
    w_src  = i_load ? {{WIDTH{1'b0}}, i_b} : r_prod;
    w_a    = i_load ? i_a : r_a;
    w_sum  = {1'b0, w_src[2*WIDTH-1:WIDTH]} + {1'b0, w_a};
    w_next = w_src[0] ? {w_sum, w_src[WIDTH-1:1]} : {1'b0, w_src[2*WIDTH-1:1]};
  end

  assign o_done    = (r_cnt == CNT_LAST);
  assign o_product = r_prod;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_a    <= '0;
      r_prod <= '0;
    end else if (i_load) begin
      r_cnt  <= CNT_W'(1);
      r_a    <= i_a;
      r_prod <= w_next;
    end else if (i_step && !o_done) begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_prod <= w_next;
    end
  end

endmodule

// File: rtl/shared_alu_seq.sv
// Handshaked shared ALU: one op in flight, registered result and flags held until taken.
// Define SHARED_ALU_MUL_EN to build the iterative multiplier for op 111 (otherwise illegal).
module shared_alu_seq
  import shared_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_err
);

  localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_result;
  flags_t           r_flags;

  op_e              w_op;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_shift_big;
  logic [WIDTH-1:0] w_alu_result;
  flags_t           w_alu_flags;
  logic             w_capture_alu;

`ifdef SHARED_ALU_MUL_EN
  logic               w_mul_load;
  logic               w_mul_step;
  logic               w_mul_done;
  logic               w_capture_mul;
  logic [2*WIDTH-1:0] w_mul_product;
  flags_t             w_mul_flags;

  shared_alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_mul_load),
    .i_step    (w_mul_step),
    .i_a       (in_a),
    .i_b       (in_b),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  always_comb begin
    w_mul_flags       = '0;
    w_mul_flags.zero  = (w_mul_product[WIDTH-1:0] == '0);
    w_mul_flags.ovf   = |w_mul_product[2*WIDTH-1:WIDTH];
  end
`endif

  // Single-cycle datapath works straight off the request; results only matter on acceptance.
  always_comb begin
    w_op         = op_e'(in_op);
    w_sum        = {1'b0, in_a} + {1'b0, in_b};
    w_diff       = {1'b0, in_a} - {1'b0, in_b};
    w_shift_big  = (in_b >= SHIFT_LIMIT);
    w_alu_result = '0;
    w_alu_flags  = '0;
    case (w_op)
      OP_ADD: begin
        w_alu_result      = w_sum[WIDTH-1:0];
        w_alu_flags.carry = w_sum[WIDTH];
        w_alu_flags.ovf   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (w_sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_result      = w_diff[WIDTH-1:0];
        w_alu_flags.carry = w_diff[WIDTH];
        w_alu_flags.ovf   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (w_diff[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND:  w_alu_result = in_a & in_b;
      OP_OR:   w_alu_result = in_a | in_b;
      OP_XOR:  w_alu_result = in_a ^ in_b;
      OP_SHL:  w_alu_result = w_shift_big ? '0 : (in_a << in_b);
      OP_SHR:  w_alu_result = w_shift_big ? '0 : (in_a >> in_b);
      default: w_alu_flags.err = 1'b1;
    endcase
    w_alu_flags.zero = (w_alu_result == '0);
  end

  always_comb begin
    w_state_next  = r_state;
    w_capture_alu = 1'b0;
`ifdef SHARED_ALU_MUL_EN
    w_mul_load    = 1'b0;
    w_mul_step    = 1'b0;
    w_capture_mul = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef SHARED_ALU_MUL_EN
          if (w_op == OP_MUL) begin
            w_mul_load   = 1'b1;
            w_state_next = ST_MUL;
          end else begin
            w_capture_alu = 1'b1;
            w_state_next  = ST_HOLD;
          end
`else
          w_capture_alu = 1'b1;
          w_state_next  = ST_HOLD;
`endif
        end
      end
`ifdef SHARED_ALU_MUL_EN
      ST_MUL: begin
        if (w_mul_done) begin
          w_capture_mul = 1'b1;
          w_state_next  = ST_HOLD;
        end else begin
          w_mul_step = 1'b1;
        end
      end
`endif
      ST_HOLD: begin
        if (out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_capture_alu) begin
        r_result <= w_alu_result;
        r_flags  <= w_alu_flags;
      end
`ifdef SHARED_ALU_MUL_EN
      else if (w_capture_mul) begin
        r_result <= w_mul_product[WIDTH-1:0];
        r_flags  <= w_mul_flags;
      end
`endif
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_HOLD);
  assign out_result = r_result;
  assign out_carry  = r_flags.carry;
  assign out_zero   = r_flags.zero;
  assign out_ovf    = r_flags.ovf;
  assign out_err    = r_flags.err;

endmodule

// File: tb/tb_shared_alu_seq.sv
// Bench for shared_alu_seq (WIDTH=8): directed plan vectors, backpressure, reset abort,
// back-to-back throughput and random ops against an arithmetic reference model.
module tb_shared_alu_seq;

  localparam int W = 8;
`ifdef SHARED_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_op = '0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_result;
  logic         out_carry, out_zero, out_ovf, out_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  shared_alu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf),
    .out_err    (out_err)
  );

  // Reference: {result, carry, zero, ovf, err} from plain integer arithmetic.
  function automatic logic [11:0] model(input int op, input int a, input int b);
    int r = 0;
    int sa, sb, s;
    bit c = 1'b0;
    bit v = 1'b0;
    bit e = 1'b0;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    case (op)
      0: begin r = a + b; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
      1: begin r = a - b; c = (a < b);   s = sa - sb; v = (s > 127) || (s < -128); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (b >= W) ? 0 : (a << b);
      6: r = (b >= W) ? 0 : (a >> b);
      default: begin
        if (MUL_EN) begin r = a * b; v = (r > 255); end
        else e = 1'b1;
      end
    endcase
    r = r & 255;
    if (e) r = 0;
    return {8'(r), c, (r == 0), v, e};
  endfunction

  function automatic int exp_lat(input int op);
    return (MUL_EN && op == 7) ? W + 1 : 1;
  endfunction

  function automatic logic [11:0] cur();
    return {out_result, out_carry, out_zero, out_ovf, out_err};
  endfunction

  // Called #1 after an edge; returns #1 after the acceptance edge with inputs scrambled.
  task automatic send(input int op, input int a, input int b);
    int n = 0;
    in_op = 3'(op); in_a = 8'(a); in_b = 8'(b); in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op = 3'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
  endtask

  // Latency counts cycles after the acceptance edge until out_valid is seen.
  task automatic wait_result(output int lat, output logic [11:0] o);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    o = cur();
  endtask

  task automatic do_txn(input int op, input int a, input int b, input int hold,
                        output int lat, output logic [11:0] o);
    out_ready = (hold == 0);
    send(op, a, b);
    wait_result(lat, o);
    $display("txn op=%0d a=%02h b=%02h -> res=%02h c=%b z=%b v=%b e=%b lat=%0d",
             op, a, b, o[11:4], o[3], o[2], o[1], o[0], lat);
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({in_ready, out_valid, cur()} !== {1'b1, 1'b0, 12'h000}) begin
      bad++;
      $display("FAIL reset_in: rdy/vld/obs=%b/%b/%03h, required 1/0/000", in_ready, out_valid, cur());
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({in_ready, out_valid, cur()} !== {1'b1, 1'b0, 12'h000}) begin
      bad++;
      $display("FAIL reset_out: rdy/vld/obs=%b/%b/%03h, required 1/0/000", in_ready, out_valid, cur());
    end
  endtask

  task automatic test_directed();
    int ops[8]  = '{0, 1, 1, 5, 6, 0, 7, 2};
    int as[8]   = '{8'hFF, 8'h80, 8'h01, 8'h81, 8'h81, 8'h7F, 8'h10, 8'hF0};
    int bs[8]   = '{8'h01, 8'h01, 8'h02, 9, 7, 8'h01, 8'h11, 8'h0F};
    logic [11:0] exp_v[8];
    int lats[8] = '{1, 1, 1, 1, 1, 1, 1, 1};
    int lat;
    logic [11:0] o;
    exp_v[0] = {8'h00, 4'b1100};
    exp_v[1] = {8'h7F, 4'b0010};
    exp_v[2] = {8'hFF, 4'b1000};
    exp_v[3] = {8'h00, 4'b0100};
    exp_v[4] = {8'h01, 4'b0000};
    exp_v[5] = {8'h80, 4'b0010};
`ifdef SHARED_ALU_MUL_EN
    exp_v[6] = {8'h10, 4'b0010};
    lats[6]  = 9;
`else
    exp_v[6] = {8'h00, 4'b0101};
`endif
    exp_v[7] = {8'h00, 4'b0100};
    for (int i = 0; i < 8; i++) begin
      do_txn(ops[i], as[i], bs[i], 0, lat, o);
      total++;
      if (o !== exp_v[i]) begin
        bad++;
        $display("FAIL directed_%0d: obs=%03h, required %03h", i, o, exp_v[i]);
      end
      total++;
      if (lat !== lats[i]) begin
        bad++;
        $display("FAIL directed_lat_%0d: latency=%0d, required %0d", i, lat, lats[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int a = $urandom_range(0, 255);
    int b = $urandom_range(0, 255);
    int a2 = $urandom_range(0, 255);
    int b2 = $urandom_range(0, 255);
    int lat;
    logic [11:0] o1;
    out_ready = 1'b0;
    send(0, a, b);
    wait_result(lat, o1);
    $display("txn op=0 a=%02h b=%02h -> res=%02h held", a, b, o1[11:4]);
    total++;
    if (o1 !== model(0, a, b)) begin
      bad++;
      $display("FAIL bp_first: obs=%03h, required %03h", o1, model(0, a, b));
    end
    in_op = 3'd4; in_a = 8'(a2); in_b = 8'(b2); in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if ({out_valid, in_ready, cur()} !== {1'b1, 1'b0, o1}) begin
        bad++;
        $display("FAIL bp_hold_%0d: vld/rdy/obs=%b/%b/%03h, required 1/0/%03h",
                 i, out_valid, in_ready, cur(), o1);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL bp_release: vld/rdy=%b/%b, required 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("txn op=4 a=%02h b=%02h -> res=%02h after release", a2, b2, out_result);
    total++;
    if ({out_valid, cur()} !== {1'b1, model(4, a2, b2)}) begin
      bad++;
      $display("FAIL bp_next: vld/obs=%b/%03h, required 1/%03h", out_valid, cur(), model(4, a2, b2));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul();
    int lat;
    logic [11:0] o;
    out_ready = 1'b0;
    send(7, 8'hB7, 8'hE5);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    $display("txn op=7 a=b7 b=e5 -> aborted by reset");
    total++;
    if ({in_ready, out_valid, cur()} !== {1'b1, 1'b0, 12'h000}) begin
      bad++;
      $display("FAIL abort: rdy/vld/obs=%b/%b/%03h, required 1/0/000", in_ready, out_valid, cur());
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    do_txn(0, 2, 3, 0, lat, o);
    total++;
    if ({o, 8'(lat)} !== {8'h05, 4'b0000, 8'd1}) begin
      bad++;
      $display("FAIL abort_add: obs=%03h lat=%0d, required 050 lat=1", o, lat);
    end
  endtask

  task automatic test_back_to_back();
    int op, a, b;
    int lat;
    logic [11:0] o;
    out_ready = 1'b1;
    op = $urandom_range(0, 6); a = $urandom_range(0, 255); b = $urandom_range(0, 255);
    send(op, a, b);
    wait_result(lat, o);
    total++;
    if (o !== model(op, a, b)) begin
      bad++;
      $display("FAIL b2b_first: obs=%03h, required %03h", o, model(op, a, b));
    end
    for (int i = 0; i < 6; i++) begin
      op = $urandom_range(0, 6); a = $urandom_range(0, 255); b = $urandom_range(0, 15);
      in_op = 3'(op); in_a = 8'(a); in_b = 8'(b); in_valid = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({in_ready, out_valid} !== 2'b10) begin
        bad++;
        $display("FAIL b2b_gap_%0d: rdy/vld=%b/%b, required 1/0", i, in_ready, out_valid);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      $display("txn op=%0d a=%02h b=%02h -> res=%02h back-to-back", op, a, b, out_result);
      total++;
      if ({out_valid, cur()} !== {1'b1, model(op, a, b)}) begin
        bad++;
        $display("FAIL b2b_%0d: vld/obs=%b/%03h, required 1/%03h", i, out_valid, cur(), model(op, a, b));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int op, a, b, hold, lat;
    logic [11:0] o;
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 7);
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 10) : $urandom_range(0, 255);
      hold = $urandom_range(0, 2);
      do_txn(op, a, b, hold, lat, o);
      total++;
      if (o !== model(op, a, b)) begin
        bad++;
        $display("FAIL rand_%0d: op=%0d a=%02h b=%02h obs=%03h, required %03h",
                 i, op, a, b, o, model(op, a, b));
      end
      total++;
      if (lat !== exp_lat(op)) begin
        bad++;
        $display("FAIL rand_lat_%0d: op=%0d latency=%0d, required %0d", i, op, lat, exp_lat(op));
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
